debouncer_multi: RTL and testbench
==================================

# debouncer_multi

Multi-channel switch debouncer, the parametrised successor to the single-channel debouncer. Each of `NumCh` asynchronous switch inputs gets a configurable-depth synchronizer, a stability counter, a debounced level, and separate rise/fall tick pulses. An optional sticky event/interrupt block is compiled in with a macro. The block sits between board-level buttons/switches and the control logic.

## Interface
- `NumCh`, default 4: number of independent channels (1..32).
- `ClkFreq`, default 100_000_000: clock frequency in Hz.
- `StableTime`, default 10: required stable time in ms.
- `SyncStages`, default 2: synchronizer flops per channel (2..4).
- `ResetLevel`, default 1'b0: reset value of synchronizer flops and debounced levels.
- `clk_i`, in, 1: single clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `sw_i`, in, NumCh: raw asynchronous switch inputs.
- `db_level_o`, out, NumCh: debounced levels.
- `db_rise_o`, out, NumCh: one-cycle pulse on a debounced 0→1 change.
- `db_fall_o`, out, NumCh: one-cycle pulse on a debounced 1→0 change.
- `evt_o`, out, NumCh: sticky event flags (`DEBOUNCER_IRQ_EN` only).
- `evt_clr_i`, in, NumCh: write-1-to-clear for `evt_o` (`DEBOUNCER_IRQ_EN` only).
- `irq_mask_i`, in, NumCh: per-channel interrupt enable (`DEBOUNCER_IRQ_EN` only).
- `irq_o`, out, 1: interrupt request (`DEBOUNCER_IRQ_EN` only).

## Operation
- `StableCycles = ClkFreq/1000*StableTime`. Elaboration error if it is < 1.
- Counter width is `$clog2(StableCycles+1)`. The counter saturates and never wraps.
- Per channel, `sync_q` is the output of the last synchronizer stage.
- When `sync_q != level_q`, the counter increments each cycle.
- When `sync_q == level_q`, the counter clears to 0 in the same cycle. Any bounce therefore restarts the count.
- When the counter equals `StableCycles-1` and `sync_q != level_q`:
  - `level_q` toggles on the next edge.
  - The counter clears.
  - `db_rise_o` or `db_fall_o` is registered high for exactly one cycle.
- Rise and fall never assert together on one channel.
- Channels are fully independent. Simultaneous changes on multiple channels produce simultaneous ticks.
- Reset values:
  - Synchronizer flops and `db_level_o` reset to `ResetLevel`.
  - Counters reset to 0.
  - `db_rise_o`, `db_fall_o`, `evt_o` and `irq_o` reset to 0.
- Holding `sw_i` at `ResetLevel` through reset produces no tick afterwards.
- Reset asserted mid-count discards the count immediately and asynchronously. No tick results.

## Timing
- Latency from a `sw_i` change (meeting setup) to `sync_q` change: `SyncStages` cycles.
- Let cycle 0 be the first cycle in which `sync_q` differs from `level_q`. If it stays different through cycle `StableCycles-1`, then `db_level_o` and the tick both appear in cycle `StableCycles`.
- Total latency from `sw_i` to `db_level_o` is `SyncStages + StableCycles` cycles.
- A glitch lasting `StableCycles-1` cycles or less at `sync_q` causes no output change.
- All outputs are registered.

## Configuration
- Macro `DEBOUNCER_IRQ_EN`.
- Defined:
  - `evt_o[i]` sets on `db_rise_o[i] | db_fall_o[i]`.
  - `evt_o[i]` clears on `evt_clr_i[i]`.
  - Set wins over clear in the same cycle.
  - `irq_o` is registered `|(evt_o & irq_mask_i)`, so it asserts one cycle after the flag.
- Undefined: the four IRQ ports and the event logic are absent. Everything else is identical.

## Structure
- Package `debouncer_pkg` holds:
  - function `stable_cycles(clk_freq, stable_time_ms)`;
  - function `cnt_width(cycles)`;
  - bounds constants `MaxCh = 32`, `MinSyncStages = 2`, `MaxSyncStages = 4`.
- Sub-module `debounce_ch` holds the synchronizer, counter, level and tick logic for one channel. It is instantiated `NumCh` times in a generate loop.
- The IRQ logic lives in the top module.

## Test plan
Common setup: `NumCh=4`, `ClkFreq=100_000`, `StableTime=1` (100 cycles), `SyncStages=2`.
- **Reset:** hold `rst_ni=0` for 5 cycles with `sw_i=4'h0`, then release. `db_level_o=0`, no ticks, `irq_o=0`.
- **Clean press:** `sw_i[0]` 0→1 and held. `db_level_o[0]=1` and a single `db_rise_o[0]` pulse exactly 102 cycles after the change. Release gives `db_fall_o[0]` after 102 cycles.
- **Bounce:** toggle `sw_i[1]` with high periods of 99 cycles and low periods of 5 cycles, ten times. No tick. After a final steady high, the rise tick arrives 102 cycles after the last edge.
- **Simultaneous channels:** `sw_i` 0→F in one cycle. All four rise ticks occur in the same cycle. Channel independence holds when `sw_i[3]` bounces while the others are steady.
- **Reset mid-count:** assert `rst_ni` at count 50. Outputs return to reset values. After release with `sw_i` still high, the full 102-cycle latency restarts.
- **IRQ (macro defined):**
  - With `irq_mask_i=4'h1`, a channel-0 rise sets `evt_o[0]` and `irq_o` asserts one cycle later.
  - `evt_clr_i[0]` pulse clears both.
  - A clear in the same cycle as a new tick leaves `evt_o[0]=1`.

Source files
------------

// File: rtl/debouncer_pkg.sv
// Shared constants and elaboration-time helpers for the multi-channel switch debouncer.
package debouncer_pkg;

    localparam int MaxCh         = 32;
    localparam int MinSyncStages = 2;
    localparam int MaxSyncStages = 4;

    // Number of clock cycles a synchronized input must differ from the level before it is accepted.
    function automatic int stable_cycles(input int clk_freq, input int stable_time_ms);
        return (clk_freq / 1000) * stable_time_ms;
    endfunction

    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchronizer chain, saturating stability counter, debounced level and edge ticks.
module debounce_ch
    import debouncer_pkg::*;
#(
    parameter int   StableCycles = 1_000_000,
    parameter int   SyncStages   = 2,
    parameter logic ResetLevel   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int              CntW    = cnt_width(StableCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(StableCycles - 1);

    logic [SyncStages-1:0] sync_r;
    logic [CntW-1:0]       cnt_q;
    logic                  level_q;
    logic                  rise_q;
    logic                  fall_q;
    logic                  sync_q;
    logic                  differ;
    logic                  accept;

    assign sync_q = sync_r[SyncStages-1];
    assign differ = sync_q ^ level_q;
    assign accept = differ && (cnt_q == CntLast);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_r <= {SyncStages{ResetLevel}};
        end else begin
            sync_r <= {sync_r[SyncStages-2:0], sw_i};
        end
    end

    // Any cycle where the synchronized input matches the level restarts the stability count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            level_q <= ResetLevel;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= accept & ~level_q;
            fall_q <= accept & level_q;
            if (accept) begin
                level_q <= ~level_q;
            end
            if (!differ || accept) begin
                cnt_q <= '0;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/debouncer_multi.sv
// NumCh-channel switch debouncer; define DEBOUNCER_IRQ_EN to add sticky event flags and a masked interrupt.
module debouncer_multi
    import debouncer_pkg::*;
#(
    parameter int   NumCh      = 4,
    parameter int   ClkFreq    = 100_000_000,
    parameter int   StableTime = 10,
    parameter int   SyncStages = 2,
    parameter logic ResetLevel = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NumCh-1:0] sw_i,
    output logic [NumCh-1:0] db_level_o,
    output logic [NumCh-1:0] db_rise_o,
    output logic [NumCh-1:0] db_fall_o
`ifdef DEBOUNCER_IRQ_EN
    ,
    output logic [NumCh-1:0] evt_o,
    input  logic [NumCh-1:0] evt_clr_i,
    input  logic [NumCh-1:0] irq_mask_i,
    output logic             irq_o
`endif
);

    localparam int StableCycles = stable_cycles(ClkFreq, StableTime);

    generate
        if (StableCycles < 1) begin : g_bad_stable
            $error("debouncer_multi: StableCycles must be at least 1");
        end
        if (NumCh < 1 || NumCh > MaxCh) begin : g_bad_numch
            $error("debouncer_multi: NumCh out of range");
        end
        if (SyncStages < MinSyncStages || SyncStages > MaxSyncStages) begin : g_bad_sync
            $error("debouncer_multi: SyncStages out of range");
        end
    endgenerate

    for (genvar i = 0; i < NumCh; i++) begin : g_ch
        debounce_ch #(
            .StableCycles(StableCycles),
            .SyncStages  (SyncStages),
            .ResetLevel  (ResetLevel)
        ) u_ch (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .sw_i   (sw_i[i]),
            .level_o(db_level_o[i]),
            .rise_o (db_rise_o[i]),
            .fall_o (db_fall_o[i])
        );
    end

`ifdef DEBOUNCER_IRQ_EN
    logic [NumCh-1:0] evt_q;
    logic             irq_q;

    // A new tick takes priority over a simultaneous clear so no event is ever lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            evt_q <= '0;
            irq_q <= 1'b0;
        end else begin
            evt_q <= (evt_q & ~evt_clr_i) | db_rise_o | db_fall_o;
            irq_q <= |(evt_q & irq_mask_i);
        end
    end

    assign evt_o = evt_q;
    assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_debouncer_multi.sv
// Scoreboard bench for debouncer_multi: stimulus queues expected ticks, a monitor checks each tick it sees.
module tb_debouncer_multi;

    localparam int NumCh   = 4;
    localparam int Latency = 102;
    localparam int ClkHalf = 5;

    typedef struct {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] level;
    } exp_t;

    logic             clk_i;
    logic             rst_ni;
    logic [NumCh-1:0] sw;
    logic [NumCh-1:0] db_level;
    logic [NumCh-1:0] db_rise;
    logic [NumCh-1:0] db_fall;
`ifdef DEBOUNCER_IRQ_EN
    logic [NumCh-1:0] evt;
    logic [NumCh-1:0] evt_clr;
    logic [NumCh-1:0] irq_mask;
    logic             irq;
`endif

    exp_t sb[$];
    int   cyc        = 0;
    int   compared   = 0;
    int   mismatched = 0;

    debouncer_multi #(
        .NumCh     (NumCh),
        .ClkFreq   (100_000),
        .StableTime(1),
        .SyncStages(2),
        .ResetLevel(1'b0)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .sw_i      (sw),
        .db_level_o(db_level),
        .db_rise_o (db_rise),
        .db_fall_o (db_fall)
`ifdef DEBOUNCER_IRQ_EN
        ,
        .evt_o     (evt),
        .evt_clr_i (evt_clr),
        .irq_mask_i(irq_mask),
        .irq_o     (irq)
`endif
    );

    initial clk_i = 1'b0;
    always #(ClkHalf) clk_i = ~clk_i;

    always @(posedge clk_i) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drives the switches at a falling edge; when a tick is expected it lands Latency edges later.
    task automatic applyStimulus(input logic [3:0] value, input bit expect_tick,
                                 input logic [3:0] rise, input logic [3:0] fall, input logic [3:0] level);
        exp_t e;
        sw = value;
        if (expect_tick) begin
            e.cyc   = cyc + Latency;
            e.rise  = rise;
            e.fall  = fall;
            e.level = level;
            sb.push_back(e);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clk_i);
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if ((db_rise | db_fall) != 4'h0) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_tick: rise=0x%0h fall=0x%0h, expected no tick (cycle %0d)",
                         db_rise, db_fall, cyc);
            end else begin
                e = sb.pop_front();
                checkOutput("tick_cycle", cyc, e.cyc);
                checkOutput("tick_rise", 32'(db_rise), 32'(e.rise));
                checkOutput("tick_fall", 32'(db_fall), 32'(e.fall));
                checkOutput("tick_level", 32'(db_level), 32'(e.level));
            end
        end
    end

    initial begin
        #(2 * ClkHalf * 60_000);
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        rst_ni = 1'b0;
        sw     = 4'h0;
`ifdef DEBOUNCER_IRQ_EN
        evt_clr  = 4'h0;
        irq_mask = 4'h1;
`endif
        waitCycles(5);
        checkOutput("rst_level", 32'(db_level), 32'h0);
        checkOutput("rst_ticks", 32'(db_rise | db_fall), 32'h0);
`ifdef DEBOUNCER_IRQ_EN
        checkOutput("rst_irq", 32'(irq), 32'h0);
        checkOutput("rst_evt", 32'(evt), 32'h0);
`endif
        rst_ni = 1'b1;
        waitCycles(20);
        checkOutput("post_rst_level", 32'(db_level), 32'h0);

        // Clean press and release on channel 0.
        applyStimulus(4'h1, 1'b1, 4'h1, 4'h0, 4'h1);
        waitCycles(150);
        checkOutput("press_level", 32'(db_level), 32'h1);
        applyStimulus(4'h0, 1'b1, 4'h0, 4'h1, 4'h0);
        waitCycles(150);

        // Channel 1 bounces: high periods one cycle short of acceptance.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'h2, 1'b0, 4'h0, 4'h0, 4'h0);
            waitCycles(99);
            applyStimulus(4'h0, 1'b0, 4'h0, 4'h0, 4'h0);
            waitCycles(5);
        end
        checkOutput("bounce_level", 32'(db_level), 32'h0);
        applyStimulus(4'h2, 1'b1, 4'h2, 4'h0, 4'h2);
        waitCycles(150);
        applyStimulus(4'h0, 1'b1, 4'h0, 4'h2, 4'h0);
        waitCycles(150);

        // All channels together, then channel 3 bounces while the rest hold.
        applyStimulus(4'hF, 1'b1, 4'hF, 4'h0, 4'hF);
        waitCycles(150);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'h7, 1'b0, 4'h0, 4'h0, 4'h0);
            waitCycles(10);
            applyStimulus(4'hF, 1'b0, 4'h0, 4'h0, 4'h0);
            waitCycles(10);
        end
        waitCycles(120);
        checkOutput("indep_level", 32'(db_level), 32'hF);
        applyStimulus(4'h7, 1'b1, 4'h0, 4'h8, 4'h7);
        waitCycles(150);
        applyStimulus(4'h0, 1'b1, 4'h0, 4'h7, 4'h0);
        waitCycles(150);

        // Reset in the middle of a count; the full latency must restart from release.
        applyStimulus(4'h1, 1'b0, 4'h0, 4'h0, 4'h0);
        waitCycles(52);
        rst_ni = 1'b0;
        #1;
        checkOutput("midrst_level", 32'(db_level), 32'h0);
        checkOutput("midrst_ticks", 32'(db_rise | db_fall), 32'h0);
        waitCycles(5);
        rst_ni = 1'b1;
        applyStimulus(4'h1, 1'b1, 4'h1, 4'h0, 4'h1);
        waitCycles(150);
        checkOutput("midrst_after", 32'(db_level), 32'h1);
`ifdef DEBOUNCER_IRQ_EN
        // Tick from the restarted count set the flag; clear it to start clean.
        evt_clr = 4'h1;
        waitCycles(1);
        evt_clr = 4'h0;
        waitCycles(2);
        checkOutput("irq_idle", 32'(irq), 32'h0);
`endif
        applyStimulus(4'h0, 1'b1, 4'h0, 4'h1, 4'h0);
        waitCycles(150);

`ifdef DEBOUNCER_IRQ_EN
        evt_clr = 4'h1;
        waitCycles(1);
        evt_clr = 4'h0;
        waitCycles(2);
        t = cyc + Latency;
        applyStimulus(4'h1, 1'b1, 4'h1, 4'h0, 4'h1);
        waitUntil(t + 1);
        checkOutput("evt_set", 32'(evt[0]), 32'h1);
        checkOutput("irq_lag", 32'(irq), 32'h0);
        waitCycles(1);
        checkOutput("irq_set", 32'(irq), 32'h1);
        evt_clr = 4'h1;
        waitCycles(1);
        evt_clr = 4'h0;
        checkOutput("evt_clr", 32'(evt[0]), 32'h0);
        waitCycles(1);
        checkOutput("irq_clr", 32'(irq), 32'h0);
        t = cyc + Latency;
        applyStimulus(4'h0, 1'b1, 4'h0, 4'h1, 4'h0);
        waitUntil(t);
        evt_clr = 4'h1;
        waitCycles(1);
        evt_clr = 4'h0;
        checkOutput("evt_set_wins", 32'(evt[0]), 32'h1);
        waitCycles(150);
`else
        t = 0;
`endif

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            compared++;
            mismatched++;
            $display("[TB] FAIL missing_tick: got none, expected tick at cycle %0d rise=0x%0h fall=0x%0h (t=%0d)",
                     e.cyc, e.rise, e.fall, t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
